morse_sequencer: RTL and testbench

MORSE_SEQUENCER -- requirements
Module: morse_sequencer

---
 rtl/morse_sequencer.sv | 166 ++++++++++++++++
 tb/tb_morse_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_sequencer.sv
// rtl/morse_sequencer.sv - Morse key timing sequencer; MORSE_WORD_SPACE_EN adds word-space code 36
module morse_sequencer #(
    parameter int CLK_PER_UNIT     = 50000000 / 10,
    parameter int DASH_UNITS       = 2,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    output logic [2:0] tr_count,
    output logic [4:0] tr_reg,
    input  logic [5:0] tr_code,
    output logic [5:0] char_code,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       err_pulse,
    output logic       ovr_pulse
);

    localparam int PW = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_UNIT - 1);
    localparam logic [3:0] DASH_U = 4'(DASH_UNITS);
    localparam logic [3:0] LGAP_U = 4'(LETTER_GAP_UNITS);
    localparam logic [3:0] WGAP_U = 4'(WORD_GAP_UNITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_SPACE,
        S_EMIT,
        S_GAP,
        S_DISCARD
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    unit_cnt_q, unit_cnt_d;
    logic [2:0]    sym_cnt_q, sym_cnt_d;
    logic [4:0]    pattern_q, pattern_d;
    logic [5:0]    char_code_q, char_code_d;
    logic          char_valid_q, char_valid_d;
    logic          err_q, err_d;
    logic          ovr_q, ovr_d;

    logic          tick;
    logic [3:0]    unit_eff;
    logic          load;
    logic [5:0]    load_code;
    logic          hold_clr;
    logic          cnt_clr;

    // unit_eff includes the unit completing on this very cycle, so thresholds fire on the exact edge
    assign tick     = (presc_q == PRESC_MAX);
    assign unit_eff = (tick && unit_cnt_q != 4'd15) ? unit_cnt_q + 4'd1 : unit_cnt_q;

    always_comb begin
        state_d      = state_q;
        sym_cnt_d    = sym_cnt_q;
        pattern_d    = pattern_q;
        char_code_d  = char_code_q;
        char_valid_d = char_valid_q & ~char_ready;
        err_d        = 1'b0;
        ovr_d        = 1'b0;
        load         = 1'b0;
        load_code    = tr_code;
        hold_clr     = 1'b0;

        case (state_q)
            S_IDLE: begin
                sym_cnt_d = 3'd0;
                pattern_d = 5'd0;
                if (key) state_d = S_MARK;
            end
            S_MARK: begin
                if (!key) begin
                    if (sym_cnt_q < 3'd5) begin
                        pattern_d = {pattern_q[3:0], (unit_eff >= DASH_U)};
                        sym_cnt_d = sym_cnt_q + 3'd1;
                        state_d   = S_SPACE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DISCARD;
                    end
                end
            end
            S_SPACE: begin
                if (unit_eff >= LGAP_U) state_d = S_EMIT;
                else if (key)           state_d = S_MARK;
            end
            S_EMIT: begin
                load      = 1'b1;
                sym_cnt_d = 3'd0;
                pattern_d = 5'd0;
                state_d   = key ? S_MARK : S_GAP;
            end
            S_GAP: begin
                if (unit_eff >= WGAP_U) begin
`ifdef MORSE_WORD_SPACE_EN
                    load      = 1'b1;
                    load_code = 6'd36;
`endif
                    state_d = S_IDLE;
                end else if (key) begin
                    state_d = S_MARK;
                end
            end
            S_DISCARD: begin
                // only an unbroken key-up run closes a discarded letter
                if (key) begin
                    hold_clr = 1'b1;
                end else if (unit_eff >= LGAP_U) begin
                    sym_cnt_d = 3'd0;
                    pattern_d = 5'd0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            if (!char_valid_q || char_ready) begin
                char_code_d  = load_code;
                char_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign cnt_clr    = hold_clr || (state_d != state_q);
    assign presc_d    = (cnt_clr || tick) ? '0 : presc_q + PW'(1);
    assign unit_cnt_d = cnt_clr ? 4'd0 : unit_eff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            unit_cnt_q   <= 4'd0;
            sym_cnt_q    <= 3'd0;
            pattern_q    <= 5'd0;
            char_code_q  <= 6'd0;
            char_valid_q <= 1'b0;
            err_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            unit_cnt_q   <= unit_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            pattern_q    <= pattern_d;
            char_code_q  <= char_code_d;
            char_valid_q <= char_valid_d;
            err_q        <= err_d;
            ovr_q        <= ovr_d;
        end
    end

    assign tr_count   = sym_cnt_q;
    assign tr_reg     = pattern_q;
    assign char_code  = char_code_q;
    assign char_valid = char_valid_q;
    assign err_pulse  = err_q;
    assign ovr_pulse  = ovr_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// tb/tb_morse_sequencer.sv - directed self-checking bench for morse_sequencer
module tb_morse_sequencer;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key;
    logic [2:0] tr_count;
    logic [4:0] tr_reg;
    logic [5:0] tr_code;
    logic [5:0] char_code;
    logic       char_valid;
    logic       char_ready;
    logic       err_pulse;
    logic       ovr_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    logic [5:0] got_q[$];
    logic [5:0] exp_q[$];
    int err_cnt = 0;
    int ovr_cnt = 0;
    int vcyc    = 0;
    int got_base, err_base, ovr_base, vcyc_base;

    morse_sequencer #(
        .CLK_PER_UNIT(U)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .tr_count  (tr_count),
        .tr_reg    (tr_reg),
        .tr_code   (tr_code),
        .char_code (char_code),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .err_pulse (err_pulse),
        .ovr_pulse (ovr_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] xlate(input logic [2:0] c, input logic [4:0] p);
        case ({c, p})
            8'b001_00000: return 6'd4;
            8'b001_00001: return 6'd19;
            8'b010_00001: return 6'd0;
            8'b010_00000: return 6'd8;
            8'b010_00010: return 6'd13;
            8'b011_00000: return 6'd18;
            8'b101_11111: return 6'd26;
            8'b101_00000: return 6'd31;
            default:      return 6'd63;
        endcase
    endfunction

    always_comb tr_code = xlate(tr_count, tr_reg);

    always @(negedge clk) begin
        #1;
        if (char_valid && char_ready) got_q.push_back(char_code);
        if (err_pulse) err_cnt++;
        if (ovr_pulse) ovr_cnt++;
        if (char_valid) vcyc++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sym(input int down_u, input int up_u);
        key = 1'b1;
        cyc(down_u * U);
        key = 1'b0;
        cyc(up_u * U);
    endtask

    task automatic begin_test();
        exp_q.delete();
        got_base  = got_q.size();
        err_base  = err_cnt;
        ovr_base  = ovr_cnt;
        vcyc_base = vcyc;
    endtask

    task automatic add_word_space();
`ifdef MORSE_WORD_SPACE_EN
        exp_q.push_back(6'd36);
`endif
    endtask

    task automatic end_test(input string tag);
        int n;
        n = got_q.size() - got_base;
        check({tag, "_nchars"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check({tag, "_code"}, got_q[got_base + i], exp_q[i]);
    endtask

    initial begin
        rst_n = 1'b0;
        key = 1'b0;
        char_ready = 1'b1;
        cyc(3);
        check("rst_char_code", char_code, 0);
        check("rst_char_valid", char_valid, 0);
        check("rst_err", err_pulse, 0);
        check("rst_ovr", ovr_pulse, 0);
        check("rst_tr_count", tr_count, 0);
        check("rst_tr_reg", tr_reg, 0);
        rst_n = 1'b1;
        cyc(2);

        // E: one unit down, long key-up
        begin_test();
        sym(1, 12);
        exp_q.push_back(6'd4); add_word_space();
        end_test("E");
        check("E_valid_cycles", vcyc - vcyc_base, exp_q.size());

        // A: dot, 3-unit dash
        begin_test();
        sym(1, 1);
        sym(3, 1);
        check("A_tr_count", tr_count, 2);
        check("A_tr_reg", tr_reg, 5'b00001);
        cyc(11 * U);
        exp_q.push_back(6'd0); add_word_space();
        end_test("A");

        // digit 0: five dashes
        begin_test();
        for (int i = 0; i < 4; i++) sym(3, 1);
        sym(3, 12);
        exp_q.push_back(6'd26); add_word_space();
        end_test("D0");
        check("D0_err", err_cnt - err_base, 0);

        // six dots overflow the letter
        begin_test();
        for (int i = 0; i < 6; i++) sym(1, 1);
        cyc(11 * U);
        end_test("SIX");
        check("SIX_err", err_cnt - err_base, 1);
        check("SIX_valid_cycles", vcyc - vcyc_base, 0);

        // I with 2-unit intra-letter gap must not close the letter
        begin_test();
        sym(1, 2);
        sym(1, 12);
        exp_q.push_back(6'd8); add_word_space();
        end_test("I");

        // N: 2-unit key-down is already a dash
        begin_test();
        sym(2, 1);
        sym(1, 12);
        exp_q.push_back(6'd13); add_word_space();
        end_test("N");

        // T held past unit-counter saturation
        begin_test();
        sym(17, 12);
        exp_q.push_back(6'd19); add_word_space();
        end_test("TLONG");

        // back-pressure: E held, T dropped
        begin_test();
        char_ready = 1'b0;
        sym(1, 4);
        sym(3, 4);
        check("OVR_code", char_code, 4);
        check("OVR_valid", char_valid, 1);
        check("OVR_pulses", ovr_cnt - ovr_base, 1);
        check("OVR_accepts", got_q.size() - got_base, 0);
        char_ready = 1'b1;
        cyc(12 * U);
        exp_q.push_back(6'd4); add_word_space();
        end_test("OVR");
        check("OVR_pulses_end", ovr_cnt - ovr_base, 1);

        // reset mid-letter
        begin_test();
        sym(1, 1);
        sym(1, 1);
        check("RST_pre_tr_count", tr_count, 2);
        rst_n = 1'b0;
        cyc(1);
        check("RST_char_code", char_code, 0);
        check("RST_char_valid", char_valid, 0);
        check("RST_tr_count", tr_count, 0);
        check("RST_tr_reg", tr_reg, 0);
        check("RST_err", err_pulse, 0);
        check("RST_ovr", ovr_pulse, 0);
        rst_n = 1'b1;
        cyc(2 * U);
        sym(3, 12);
        exp_q.push_back(6'd19); add_word_space();
        end_test("RST");
        check("RST_err_cnt", err_cnt - err_base, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
